// File: rtl/dequant_pkg.sv
// +-----------------------------------------------------------------------+
// | dequant_pkg : shared constants, zigzag table and FSM states            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package dequant_pkg;

  localparam int NCOEF = 16;
  localparam int CW    = 16;
  localparam int QW    = 16;

  // Zigzag beat index -> raster slot.
  localparam logic [3:0] ZZ [NCOEF] = '{
    4'd0,  4'd1,  4'd4,  4'd8,  4'd5,  4'd2,  4'd3,  4'd6,
    4'd9,  4'd12, 4'd13, 4'd10, 4'd7,  4'd11, 4'd14, 4'd15
  };

  typedef enum logic [1:0] {
    FILL = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dequant_block_if.sv
// +-----------------------------------------------------------------------+
// | dequant_block_if : level stream in, parallel coefficient block out     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface dequant_block_if
  import dequant_pkg::*;
#(
  parameter int IW = 16
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic signed [IW-1:0]   in_level;
  logic                   in_last;
  logic [NCOEF*QW-1:0]    q;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCOEF*CW-1:0]    out;
  logic                   nz;
  logic [4:0]             eob;

  modport master (
    output in_valid, in_level, in_last, q, out_ready,
    input  in_ready, out_valid, out, nz, eob
  );

  modport slave (
    input  in_valid, in_level, in_last, q, out_ready,
    output in_ready, out_valid, out, nz, eob
  );

endinterface

`default_nettype wire

// File: rtl/dequant_mul.sv
// +-----------------------------------------------------------------------+
// | dequant_mul : level x step with 16-bit reduction                      |
// | Saturates when DEQUANT_CLAMP_EN is defined, else wraps. Rev 1.0        |
// +-----------------------------------------------------------------------+
`default_nettype none

module dequant_mul
  import dequant_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic signed [IW-1:0] level,
  input  logic [QW-1:0]        q,
  output logic [CW-1:0]        coef
);

  localparam int PW = IW + QW + 1;

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_prod;

  assign w_a    = PW'(level);
  assign w_b    = PW'({1'b0, q});
  assign w_prod = w_a * w_b;

`ifdef DEQUANT_CLAMP_EN
  // In range iff every bit above the 16-bit sign bit equals it.
  logic w_in_range;
  assign w_in_range = (&w_prod[PW-1:CW-1]) | ~(|w_prod[PW-1:CW-1]);

  always_comb begin
    coef = w_prod[CW-1:0];
    if (!w_in_range) begin
      coef = w_prod[PW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_prod[PW-1:CW];
  assign coef        = w_prod[CW-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/dequant_block.sv
// +-----------------------------------------------------------------------+
// | dequant_block : de-zigzag, dequantize and present a 4x4 block          |
// | Optional saturation via DEQUANT_CLAMP_EN. Rev 1.0                     |
// +-----------------------------------------------------------------------+
`default_nettype none

module dequant_block
  import dequant_pkg::*;
#(
  parameter int BLOCK_SIZE = 4,
  parameter int IW         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  dequant_block_if.slave  bus
);

  localparam int c_nslot = BLOCK_SIZE * BLOCK_SIZE;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [3:0]             r_cnt;
  logic signed [IW-1:0]   r_lvl [NCOEF];
  logic [4:0]             r_eob_pend;
  logic [4:0]             r_eob;
  logic                   r_nz;
  logic [NCOEF*CW-1:0]    r_out;
  logic [NCOEF*CW-1:0]    w_coef_flat;
  logic                   w_nz;
  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_accept;
  logic                   w_done;
  logic                   w_handshake;

  assign w_accept    = bus.in_valid & (r_state == FILL);
  assign w_done      = w_accept & (bus.in_last | (r_cnt == 4'(NCOEF - 1)));
  assign w_handshake = (r_state == OUT) & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      FILL: begin
        w_in_ready = 1'b1;
        if (w_done) begin
          w_state_next = MUL;
        end
      end
      MUL: begin
        w_state_next = OUT;
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = FILL;
        end
      end
      default: begin
        w_state_next = FILL;
      end
    endcase
  end

  // Level buffer and beat counter; cleared when the block is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_eob_pend <= '0;
      for (int i = 0; i < NCOEF; i++) begin
        r_lvl[i] <= '0;
      end
    end else if (w_handshake) begin
      r_cnt <= '0;
      for (int i = 0; i < NCOEF; i++) begin
        r_lvl[i] <= '0;
      end
    end else if (w_accept) begin
      r_lvl[ZZ[r_cnt]] <= bus.in_level;
      r_cnt            <= r_cnt + 4'd1;
      if (w_done) begin
        r_eob_pend <= {1'b0, r_cnt} + 5'd1;
      end
    end
  end

  always_comb begin
    w_nz = 1'b0;
    for (int i = 0; i < NCOEF; i++) begin
      if (r_lvl[i] != '0) begin
        w_nz = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < c_nslot; i++) begin : g_mul
    dequant_mul #(
      .IW (IW)
    ) u_mul (
      .level (r_lvl[i]),
      .q     (bus.q[i*QW +: QW]),
      .coef  (w_coef_flat[i*CW +: CW])
    );
  end

  // Output registers load only on the MUL->OUT edge so they hold through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_nz  <= 1'b0;
      r_eob <= '0;
    end else if (r_state == MUL) begin
      r_out <= w_coef_flat;
      r_nz  <= w_nz;
      r_eob <= r_eob_pend;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out       = r_out;
  assign bus.nz        = r_nz;
  assign bus.eob       = r_eob;

endmodule

`default_nettype wire

// File: doc/dequant_block.md
# dequant_block

Decoder-side inverse of the encoder quantizer. It accepts quantized levels for one 4x4 block as a serial zigzag-ordered stream, one level per beat, from the coefficient token decoder. It de-zigzags the levels into raster order and multiplies each by its per-position quantizer step. It then presents the 16 dequantized coefficients in parallel, with a valid/ready handshake, to the inverse transform.

## Interface
Parameters:
- BLOCK_SIZE, 4, block edge; only 4 is supported.
- IW, 16, signed level width on the input stream.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  level beat valid.
- in_ready  out  1  block can accept a beat.
- in_level  in  IW  signed quantized level, zigzag order.
- in_last  in  1  final non-zero beat of the block (end of block).
- q  in  256  16 unsigned 16-bit steps, raster order, slot i = bits [16i+15:16i].
- out_valid  out  1  dequantized block available.
- out_ready  in  1  consumer accepts the block.
- out  out  256  16 signed 16-bit coefficients, raster order.
- nz  out  1  at least one stored level is non-zero.
- eob  out  5  number of beats received, 1..16.

## Operation
- States: FILL, MUL, OUT.
- FILL:
  - in_ready=1.
  - Each accepted beat (in_valid&in_ready) writes in_level to the raster slot ZZ[k], where k is the beat counter 0..15.
  - ZZ = 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
  - Slots never written stay 0.
- Block completion happens on the beat with in_last=1, or on beat k=15 regardless of in_last (implicit end of block). On completion, state goes to MUL and eob is latched as k+1.
- MUL:
  - in_ready=0.
  - q is sampled in this cycle and must be stable during it.
  - For each slot: product = sign-extended level × zero-extended q, kept at full 32+ bits, then reduced to 16 bits (see Configuration).
  - nz = OR of (level != 0) over all 16 slots.
  - State goes to OUT.
- OUT:
  - out_valid=1; out, nz and eob are held stable; in_ready=0.
  - On out_valid&out_ready: state goes to FILL, the level buffer and beat counter are cleared, and out_valid drops.
- Reset values: state FILL, in_ready=1, out_valid=0, out=0, nz=0, eob=0, buffer=0, counter=0.
- Asynchronous reset in any state (mid-fill, MUL, or OUT) discards the partial block and returns to the reset values. No beat is lost after reset deasserts.
- in_valid while in_ready=0 is ignored (not consumed).

## Timing
- Let edge E be the edge that accepts the completing beat.
  - Edge E+1: MUL registers the products; out_valid=1 is visible after E+1.
  - Latency from last beat to out_valid is therefore 1 cycle.
- Let edge H be the handshake edge (out_valid&out_ready). in_ready=1 in the cycle after H.
  - Minimum block period is therefore beats+2 cycles.
- out_ready may be held low indefinitely; outputs must not change while out_valid=1.
- nz and eob change only at the MUL→OUT edge and at reset.

## Configuration
- DEQUANT_CLAMP_EN defined: each product saturates to [-32768, 32767].
- DEQUANT_CLAMP_EN undefined: each product is truncated to its low 16 bits (two's-complement wrap). This costs less area and is valid only when the stream is known to be in range.

## Structure
- Shared package (dequant_pkg):
  - ZZ table constant.
  - State enum {FILL, MUL, OUT}.
  - Constants: NCOEF=16, CW=16 coefficient width, QW=16 step width.
- Sub-module dequant_mul: one level×q multiply plus the 16-bit reduction (clamp or wrap under DEQUANT_CLAMP_EN). It is instantiated 16 times by a generate loop.
- Top-level content: FSM, beat counter, level buffer, output registers.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0, then release.
  - Required: in_ready=1, out_valid=0, out=0, nz=0, eob=0.
- Full block:
  - Stimulus: 16 beats, level k+1, q all 2, in_last on beat 15.
  - Required: out_valid 1 cycle after the last beat; raster slot 4 = 6, slot 15 = 32, slot 2 = 12; nz=1; eob=16.
- Early end of block:
  - Stimulus: single beat, level -3, in_last=1, q[0]=100.
  - Required: out[0]=-300, slots 1..15 = 0, eob=1, nz=1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with in_valid=1, then out_ready=1.
  - Required while stalled: out stable, in_ready=0, no beats consumed.
  - Required after release: handshake, then in_ready=1 the next cycle and the next block starts at slot 0.
- Arithmetic:
  - Stimulus: level 2047, q 127 (product 259969).
  - Required: with DEQUANT_CLAMP_EN, output 32767; without it, output -2175. Repeat with level -2048 and q 127; with DEQUANT_CLAMP_EN, output -32768.
- Zero block and mid-fill reset:
  - Stimulus: single beat, level 0, in_last=1.
  - Required: nz=0, out all 0, eob=1.
  - Stimulus: assert rst_n low after 7 beats of a block.
  - Required: outputs at reset values; the next block fills from slot 0 with stale slots zero.
